// File: rtl/alu_muldiv_sequencer.sv
// Sequences 32-step unsigned MULTU/DIVU on the shared ALU: drives its operands each
// iteration, consumes its same-cycle result, and writes HI/LO at completion.
module alu_muldiv_sequencer #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  ADD_OP     = 3'b011,
  parameter logic [2:0]  SUB_OP     = 3'b100,
  parameter logic [2:0]  IDLE_OP    = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [2:0]            alu_operation,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  localparam int                   CNT_W   = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES   = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_r, state_next_s;
  logic [CNT_W-1:0]        counter_r, counter_next_s;
  // acc_hi holds the product high half / remainder, acc_lo the multiplier / quotient,
  // operand the multiplicand / divisor.
  logic [DATA_WIDTH-1:0]   acc_hi_r, acc_hi_next_s;
  logic [DATA_WIDTH-1:0]   acc_lo_r, acc_lo_next_s;
  logic [DATA_WIDTH-1:0]   operand_r, operand_next_s;
  logic [DATA_WIDTH-1:0]   hi_r, hi_next_s;
  logic [DATA_WIDTH-1:0]   lo_r, lo_next_s;
  logic                    dbz_r, dbz_next_s;
  logic                    busy_r, done_r;
  logic                    carry_s;
  logic                    c_s;
  logic [DATA_WIDTH-1:0]   rem_s;

  // Next-state, datapath update and ALU drive.
  always_comb begin
    state_next_s   = state_r;
    counter_next_s = counter_r;
    acc_hi_next_s  = acc_hi_r;
    acc_lo_next_s  = acc_lo_r;
    operand_next_s = operand_r;
    hi_next_s      = hi_r;
    lo_next_s      = lo_r;
    dbz_next_s     = dbz_r;
    alu_operation  = IDLE_OP;
    alu_a          = ZERO;
    alu_b          = ZERO;
    carry_s        = 1'b0;
    c_s            = acc_hi_r[DATA_WIDTH-1];
    rem_s          = {acc_hi_r[DATA_WIDTH-2:0], acc_lo_r[DATA_WIDTH-1]};

    case (state_r)
      IDLE: begin
        if (start) begin
          counter_next_s = {CNT_W{1'b0}};
          dbz_next_s     = 1'b0;
          if (!op) begin
            operand_next_s = rs_data;
            acc_hi_next_s  = ZERO;
            acc_lo_next_s  = rt_data;
            state_next_s   = MUL;
          end else if (rt_data != ZERO) begin
            operand_next_s = rt_data;
            acc_hi_next_s  = ZERO;
            acc_lo_next_s  = rs_data;
            state_next_s   = DIV;
          end else begin
            hi_next_s    = rs_data;
            lo_next_s    = ONES;
            dbz_next_s   = 1'b1;
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        alu_operation  = ADD_OP;
        alu_a          = acc_hi_r;
        alu_b          = acc_lo_r[0] ? operand_r : ZERO;
        // The ALU has no carry-out, so recover it from unsigned wrap.
        carry_s        = (alu_result < acc_hi_r);
        {acc_hi_next_s, acc_lo_next_s} = {carry_s, alu_result, acc_lo_r[DATA_WIDTH-1:1]};
        counter_next_s = counter_r + CNT_ONE;
        if (counter_r == CNT_LAST) begin
          hi_next_s    = acc_hi_next_s;
          lo_next_s    = acc_lo_next_s;
          state_next_s = DONE;
        end else begin
          state_next_s = MUL;
        end
      end
      DIV: begin
        alu_operation  = SUB_OP;
        alu_a          = rem_s;
        alu_b          = operand_r;
        // With c set the true 33-bit partial remainder exceeds the divisor and the
        // 32-bit wrapped difference is exact.
        if (c_s || (rem_s >= operand_r)) begin
          acc_hi_next_s = alu_result;
          acc_lo_next_s = {acc_lo_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_next_s = rem_s;
          acc_lo_next_s = {acc_lo_r[DATA_WIDTH-2:0], 1'b0};
        end
        counter_next_s = counter_r + CNT_ONE;
        if (counter_r == CNT_LAST) begin
          hi_next_s    = acc_hi_next_s;
          lo_next_s    = acc_lo_next_s;
          state_next_s = DONE;
        end else begin
          state_next_s = DIV;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= {CNT_W{1'b0}};
      acc_hi_r  <= ZERO;
      acc_lo_r  <= ZERO;
      operand_r <= ZERO;
      hi_r      <= ZERO;
      lo_r      <= ZERO;
      dbz_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      counter_r <= counter_next_s;
      acc_hi_r  <= acc_hi_next_s;
      acc_lo_r  <= acc_lo_next_s;
      operand_r <= operand_next_s;
      hi_r      <= hi_next_s;
      lo_r      <= lo_next_s;
      dbz_r     <= dbz_next_s;
      busy_r    <= (state_next_s == MUL) || (state_next_s == DIV);
      done_r    <= (state_next_s == DONE);
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Randomized + directed bench for alu_muldiv_sequencer; a behavioural ALU and a
// plain-arithmetic MULTU/DIVU reference model supply every expected value.
module tb_alu_muldiv_sequencer;

  localparam logic [2:0] ADD_OP  = 3'b011;
  localparam logic [2:0] SUB_OP  = 3'b100;
  localparam logic [2:0] IDLE_OP = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_operation;

  int checks = 0;
  int errors = 0;

  alu_muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour: add, subtract, or forced zero.
  assign alu_result = (alu_operation == ADD_OP) ? alu_a + alu_b :
                      (alu_operation == SUB_OP) ? alu_a - alu_b : 32'd0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check latency, busy window, ALU op and results.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int inj_k);
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz;
    logic [63:0] prod;
    int          exp_k, exp_busy, got_k, busy_cnt, op_bad;
    logic [2:0]  exp_op;

    if (!o) begin
      prod = {32'd0, a} * {32'd0, b};
      exp_hi = prod[63:32]; exp_lo = prod[31:0]; exp_dbz = 1'b0;
      exp_k = 33; exp_busy = 32; exp_op = ADD_OP;
    end else if (b == 32'd0) begin
      exp_hi = a; exp_lo = 32'hFFFF_FFFF; exp_dbz = 1'b1;
      exp_k = 1; exp_busy = 0; exp_op = SUB_OP;
    end else begin
      exp_hi = a % b; exp_lo = a / b; exp_dbz = 1'b0;
      exp_k = 33; exp_busy = 32; exp_op = SUB_OP;
    end

    start = 1'b1; op = o; rs_data = a; rt_data = b;
    got_k = 0; busy_cnt = 0; op_bad = 0;
    for (int k = 1; k <= 40 && got_k == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got_k = k;
      if (busy) begin
        busy_cnt++;
        if (alu_operation != exp_op) op_bad++;
      end
      if (k == inj_k) begin
        start = 1'b1; op = ~o; rs_data = $urandom; rt_data = $urandom;
      end
    end
    start = 1'b0;
    check_value("latency", 64'(got_k), 64'(exp_k));
    check_value("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check_value("alu_op_during_busy", 64'(op_bad), 64'd0);
    check_value("hi", {32'd0, hi}, {32'd0, exp_hi});
    check_value("lo", {32'd0, lo}, {32'd0, exp_lo});
    check_value("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dbz});
    @(negedge clk);
    check_value("done_one_cycle", {63'd0, done}, 64'd0);
    check_value("idle_alu_op", {61'd0, alu_operation}, {61'd0, IDLE_OP});
    check_value("idle_alu_ab", {alu_a, alu_b}, 64'd0);
    check_value("hi_lo_hold", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int sel;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
    check_value("rst_hi_lo", {hi, lo}, 64'd0);
    check_value("rst_alu_op", {61'd0, alu_operation}, {61'd0, IDLE_OP});
    check_value("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'd6, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'd2, 32'd3, 0);
    run_op(1'b0, 32'd3, 32'd4, 11);
    run_op(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 20);

    // Reset at iteration 20 of a divide abandons it and clears everything.
    start = 1'b1; op = 1'b1; rs_data = 32'd1000; rt_data = 32'd7;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("midrst_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
    check_value("midrst_hi_lo", {hi, lo}, 64'd0);
    check_value("midrst_alu_op", {61'd0, alu_operation}, {61'd0, IDLE_OP});
    run_op(1'b1, 32'd9, 32'd3, 0);

    // A start coinciding with reset is dropped.
    reset = 1'b1; start = 1'b1; op = 1'b0; rs_data = 32'd11; rt_data = 32'd13;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_value("start_with_reset_dropped", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      ra = $urandom;
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
